// File: rtl/microc_pkg.sv
// Shared definitions for the microc sequencing control unit: instruction
// class codes, ALU op codes, FSM states and the datapath control bundle.
package microc_pkg;

   // Instruction classes, Opcode[5:3]
   localparam logic [2:0] CL_ALU  = 3'b000;
   localparam logic [2:0] CL_ALUI = 3'b001;
   localparam logic [2:0] CL_LI   = 3'b010;
   localparam logic [2:0] CL_JMP  = 3'b011;
   localparam logic [2:0] CL_JZ   = 3'b100;
   localparam logic [2:0] CL_JNZ  = 3'b101;
   localparam logic [2:0] CL_NOP  = 3'b110;
   localparam logic [2:0] CL_HALT = 3'b111;

   // ALU op codes
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we;
      logic       wez;
      logic [2:0] op;
      logic       pc_en;
   } ctrl_t;

   // Controls of an executing cycle before the class decode refines them
   localparam ctrl_t CTRL_EXEC = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0,
                                   wez: 1'b0, op: OP_PASS, pc_en: 1'b1};
   // Controls of a non-executing cycle (IDLE, HALTED, reset)
   localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0,
                                   wez: 1'b0, op: OP_PASS, pc_en: 1'b0};

endpackage

// File: rtl/uc_ctrl_if.sv
// Control-unit bus: instruction/flag/run inputs toward the controller and
// the decoded datapath controls plus status back out.
interface uc_ctrl_if #(parameter int CNT_W = 16);
   logic [5:0]       Opcode;
   logic             z;
   logic             run;
   logic             step_req;
   logic             s_inc;
   logic             s_inm;
   logic             we;
   logic             wez;
   logic [2:0]       Op;
   logic             pc_en;
   logic             halted;
   logic             step_ack;
   logic [CNT_W-1:0] instr_cnt;

   // CPU top / bench side
   modport master (
      output Opcode, z, run, step_req,
      input  s_inc, s_inm, we, wez, Op, pc_en, halted, step_ack, instr_cnt
   );

   // Controller side
   modport slave (
      input  Opcode, z, run, step_req,
      output s_inc, s_inm, we, wez, Op, pc_en, halted, step_ack, instr_cnt
   );
endinterface

// File: rtl/uc_decode.sv
// Combinational opcode decode into the datapath control bundle, assuming
// the cycle is executing; the caller gates it for idle states.
module uc_decode
   import microc_pkg::*;
(
   input  logic [5:0] Opcode,
   input  logic       z,
   output ctrl_t      ctrl
);

   // Class decode on top of the executing-cycle defaults
   always_comb begin
      ctrl = CTRL_EXEC;
      case (Opcode[5:3])
         CL_ALU: begin
            ctrl.we  = 1'b1;
            ctrl.wez = 1'b1;
            ctrl.op  = Opcode[2:0];
         end
         CL_ALUI: begin
            ctrl.we    = 1'b1;
            ctrl.wez   = 1'b1;
            ctrl.s_inm = 1'b1;
            ctrl.op    = Opcode[2:0];
         end
         CL_LI: begin
            ctrl.we    = 1'b1;
            ctrl.s_inm = 1'b1;
         end
         CL_JMP:  ctrl.s_inc = 1'b0;
         // z is the flag from the previous instruction, never this cycle's
         CL_JZ:   ctrl.s_inc = ~z;
         CL_JNZ:  ctrl.s_inc = z;
         CL_HALT: ctrl.pc_en = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: rtl/uc_ctrl.sv
// microc sequencing control: run/step/halt FSM, step edge detector,
// saturating retired-instruction counter, and gating of decoded controls.
module uc_ctrl
   import microc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic     clk,
   input  logic     reset,
   uc_ctrl_if.slave bus
);

   state_t           state;
   logic             step_q;
   logic             halted_q;
   logic             ack_q;
   logic [CNT_W-1:0] cnt;
   ctrl_t            dec;
   ctrl_t            ctrl;
   logic             exec;
   logic             is_halt;
   logic             step_edge;

   uc_decode u_dec (
      .Opcode (bus.Opcode),
      .z      (bus.z),
      .ctrl   (dec)
   );

   assign exec      = (state == ST_RUN) || (state == ST_STEP);
   assign is_halt   = (bus.Opcode[5:3] == CL_HALT);
   assign step_edge = bus.step_req & ~step_q;
   // Gated from the state register so an async reset clears writes at once
   assign ctrl      = exec ? dec : CTRL_IDLE;

   // Execution FSM with registered halted/step_ack and step edge capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         step_q   <= 1'b0;
         halted_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         step_q <= bus.step_req;
         ack_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.run) begin
                  state <= ST_RUN;
               end else if (step_edge) begin
                  state <= ST_STEP;
                  ack_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (is_halt) begin
                  state    <= ST_HALTED;
                  halted_q <= 1'b1;
               end else if (!bus.run) begin
                  state <= ST_IDLE;
               end
            end
            ST_STEP: begin
               if (is_halt) begin
                  state    <= ST_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: ;  // HALTED is left only through reset
         endcase
      end
   end

   // Retired-instruction count, saturating at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (exec && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

   assign bus.s_inc     = ctrl.s_inc;
   assign bus.s_inm     = ctrl.s_inm;
   assign bus.we        = ctrl.we;
   assign bus.wez       = ctrl.wez;
   assign bus.Op        = ctrl.op;
   assign bus.pc_en     = ctrl.pc_en;
   assign bus.halted    = halted_q;
   assign bus.step_ack  = ack_q;
   assign bus.instr_cnt = cnt;

endmodule

// File: tb/tb_uc_ctrl.sv
// Bench for uc_ctrl: a 16-bit-counter instance and a 2-bit-counter instance
// share one stimulus; a behavioural model is compared every cycle and
// directed literal checks pin the model.
module tb_uc_ctrl;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   uc_ctrl_if #(.CNT_W(16)) mif ();
   uc_ctrl_if #(.CNT_W(2))  sif ();

   assign sif.Opcode   = mif.Opcode;
   assign sif.z        = mif.z;
   assign sif.run      = mif.run;
   assign sif.step_req = mif.step_req;

   uc_ctrl #(.CNT_W(16)) dut   (.clk(clk), .reset(rst), .bus(mif));
   uc_ctrl #(.CNT_W(2))  dut_s (.clk(clk), .reset(rst), .bus(sif));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 run, 2 step, 3 halted
   int   m_mode;
   int   m_cnt;
   logic m_prev_step;

   // Expected {s_inc,s_inm,we,wez,Op[2:0],pc_en} from the opcode table
   function automatic logic [7:0] exp_ctrl(input int mode, input logic [5:0] opc,
                                           input logic zf);
      logic s_inc, s_inm, we, wez, pc_en;
      logic [2:0] op;
      s_inc = 1'b1; s_inm = 1'b0; we = 1'b0; wez = 1'b0; op = 3'b000; pc_en = 1'b0;
      if (mode == 1 || mode == 2) begin
         pc_en = 1'b1;
         case (opc[5:3])
            3'd0: begin we = 1'b1; wez = 1'b1; op = opc[2:0]; end
            3'd1: begin we = 1'b1; wez = 1'b1; s_inm = 1'b1; op = opc[2:0]; end
            3'd2: begin we = 1'b1; s_inm = 1'b1; end
            3'd3: s_inc = 1'b0;
            3'd4: s_inc = !zf;
            3'd5: s_inc = zf;
            3'd7: pc_en = 1'b0;
            default: ;
         endcase
      end
      return {s_inc, s_inm, we, wez, op, pc_en};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = 0; m_cnt = 0; m_prev_step = 1'b0;
      end else begin
         logic edge_seen;
         edge_seen = mif.step_req && !m_prev_step;
         m_prev_step = mif.step_req;
         if (m_mode == 0) begin
            if (mif.run) m_mode = 1;
            else if (edge_seen) m_mode = 2;
         end else if (m_mode == 1 || m_mode == 2) begin
            m_cnt++;
            if (mif.Opcode[5:3] == 3'd7) m_mode = 3;
            else if (m_mode == 2 || !mif.run) m_mode = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      logic [7:0] e;
      e = exp_ctrl(m_mode, mif.Opcode, mif.z);
      chk("ctrl16", {24'd0, mif.s_inc, mif.s_inm, mif.we, mif.wez, mif.Op, mif.pc_en}, {24'd0, e});
      chk("ctrl2",  {24'd0, sif.s_inc, sif.s_inm, sif.we, sif.wez, sif.Op, sif.pc_en}, {24'd0, e});
      chk("halted", {31'd0, mif.halted},   {31'd0, m_mode == 3});
      chk("step_ack", {31'd0, mif.step_ack}, {31'd0, m_mode == 2});
      chk("cnt16", {16'd0, mif.instr_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
      chk("cnt2",  {30'd0, sif.instr_cnt}, (m_cnt > 3) ? 32'd3 : m_cnt);
   end

   // ---------------- directed stimulus ----------------
   localparam logic [5:0] I_NOP  = 6'b110_000;
   localparam logic [5:0] I_LI   = 6'b010_000;
   localparam logic [5:0] I_SUB  = 6'b000_011;
   localparam logic [5:0] I_ADDI = 6'b001_010;
   localparam logic [5:0] I_JNZ  = 6'b101_000;
   localparam logic [5:0] I_JZ   = 6'b100_000;
   localparam logic [5:0] I_HALT = 6'b111_000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acks;
      int sat_seq [5];
      sat_seq = '{1, 2, 3, 3, 3};
      n_chk = 0; n_err = 0;
      rst = 1'b0;
      mif.Opcode = I_NOP; mif.z = 1'b0; mif.run = 1'b0; mif.step_req = 1'b0;
      repeat (3) tick();
      rst = 1'b1;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_pc_en", {31'd0, mif.pc_en}, 32'd0);
         chk("idle_we",    {31'd0, mif.we},    32'd0);
         chk("idle_cnt",   {16'd0, mif.instr_cnt}, 32'd0);
      end

      // Saturating 2-bit counter over five NOPs
      mif.run = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sat_cnt2", {30'd0, sif.instr_cnt}, sat_seq[i]);
      end

      // Async reset in the middle of an LI write
      mif.Opcode = I_LI;
      #1;
      chk("li_before_rst_we", {31'd0, mif.we}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_we",    {31'd0, mif.we},    32'd0);
      chk("rst_pc_en", {31'd0, mif.pc_en}, 32'd0);
      chk("rst_s_inc", {31'd0, mif.s_inc}, 32'd1);
      chk("rst_cnt",   {16'd0, mif.instr_cnt}, 32'd0);
      tick();
      rst = 1'b1;
      tick();  // IDLE -> RUN at this edge

      // LI, SUB, JNZ with z=0
      mif.Opcode = I_LI; #1;
      chk("li_we",    {31'd0, mif.we},    32'd1);
      chk("li_s_inm", {31'd0, mif.s_inm}, 32'd1);
      chk("li_wez",   {31'd0, mif.wez},   32'd0);
      tick();
      mif.Opcode = I_SUB; #1;
      chk("sub_op",  {29'd0, mif.Op},  32'd3);
      chk("sub_wez", {31'd0, mif.wez}, 32'd1);
      tick();
      mif.Opcode = I_JNZ; mif.z = 1'b0; #1;
      chk("jnz_s_inc", {31'd0, mif.s_inc}, 32'd0);
      tick();
      chk("cnt_after3", {16'd0, mif.instr_cnt}, 32'd3);

      // JZ taken / not taken, then ALU immediate
      mif.Opcode = I_JZ; mif.z = 1'b1; #1;
      chk("jz_z1_s_inc", {31'd0, mif.s_inc}, 32'd0);
      tick();
      mif.z = 1'b0; #1;
      chk("jz_z0_s_inc", {31'd0, mif.s_inc}, 32'd1);
      tick();
      mif.Opcode = I_ADDI; #1;
      chk("addi_s_inm", {31'd0, mif.s_inm}, 32'd1);
      chk("addi_op",    {29'd0, mif.Op},    32'd2);
      tick();

      // run falls: that cycle still commits
      mif.Opcode = I_NOP; mif.run = 1'b0;
      tick();
      chk("run_fall_cnt", {16'd0, mif.instr_cnt}, 32'd7);
      tick();
      chk("back_idle_pc_en", {31'd0, mif.pc_en}, 32'd0);

      // step_req held three cycles -> exactly one STEP
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         mif.step_req = (i < 3);
         tick();
         if (mif.step_ack) acks++;
      end
      chk("step_ack_count", acks, 32'd1);
      chk("step_cnt", {16'd0, mif.instr_cnt}, 32'd8);

      // HALT in RUN
      mif.run = 1'b1;
      tick();
      mif.Opcode = I_HALT; #1;
      chk("halt_pc_en",  {31'd0, mif.pc_en},  32'd0);
      chk("halt_halted", {31'd0, mif.halted}, 32'd0);
      tick();
      chk("halted_next", {31'd0, mif.halted}, 32'd1);
      chk("halt_cnt", {16'd0, mif.instr_cnt}, 32'd9);
      mif.Opcode = I_LI;
      for (int i = 0; i < 6; i++) begin
         mif.run = i[0];
         mif.step_req = i[1];
         tick();
         chk("stay_halted", {31'd0, mif.halted}, 32'd1);
         chk("halted_we",   {31'd0, mif.we},     32'd0);
      end
      chk("halted_cnt_hold", {16'd0, mif.instr_cnt}, 32'd9);

      // Reset releases HALTED
      mif.run = 1'b0; mif.step_req = 1'b0;
      rst = 1'b0; #1;
      chk("rst_unhalt", {31'd0, mif.halted}, 32'd0);
      tick();
      rst = 1'b1;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
